// File: rtl/mem_stream_reader_pkg.sv
// ============================================================================
// mem_stream_reader_pkg
// Constants and helpers shared by the burst reader and its output buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_stream_reader_pkg;

    localparam int unsigned c_BUF_ENTRIES = 2;

    function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/common_defs.sv
// ============================================================================
// common_defs
// Shared preprocessor helpers for the memory streaming blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef COMMON_DEFS_SV
`define COMMON_DEFS_SV

// Clamped to 1 so that a DEPTH of 1 still yields a legal one-bit address.
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

`endif
`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
// stream_skid_buf
// Two-entry in-order buffer between the RAM read port and the stream output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_level
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_level;
    logic             w_pop;

    assign w_pop   = i_ready && (r_level != 2'd0);
    assign o_valid = (r_level != 2'd0);
    assign o_data  = r_head;
    assign o_level = r_level;

    // The head only moves on a pop, which keeps o_data stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= 2'd0;
        end else begin
            case ({i_valid, w_pop})
                2'b10: begin
                    if (r_level == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_level <= r_level + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_level <= r_level - 2'd1;
                end
                2'b11: begin
                    if (r_level == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stream_reader.sv
// ============================================================================
// mem_stream_reader
// Reads a wrapping burst from a registered single-port RAM onto a valid/ready stream.
// Revision: 1.0
// ============================================================================
`include "common_defs.sv"
`default_nettype none

module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [`CLOG2(DEPTH)-1:0]    base,
    input  logic [`CLOG2(DEPTH+1)-1:0]  count,
    output logic                        busy,
    output logic                        done,
    output logic [`CLOG2(DEPTH)-1:0]    mem_address,
    output logic                        mem_wr_en,
    input  logic [WIDTH-1:0]            mem_q,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int c_ADDR_W = `CLOG2(DEPTH);
    localparam int c_CNT_W  = `CLOG2(DEPTH+1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_CNT_W-1:0]  r_remaining;
    logic [c_CNT_W-1:0]  r_out_left;
    logic                r_inflight;
    logic                r_zero_done;

    logic                w_buf_valid;
    logic [1:0]          w_level;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_issue;
    logic                w_last_pop;
    logic [c_ADDR_W-1:0] w_next_addr;

    assign out_valid   = w_buf_valid && !reset;
    assign w_pop       = out_valid && out_ready;
    assign busy        = (r_state != c_ST_IDLE) && !reset;
    assign mem_address = reset ? '0 : r_addr;
    assign mem_wr_en   = 1'b0;

    // Occupancy after this cycle's pop; the word on mem_q lands in the buffer next edge.
    assign w_occ       = {1'b0, w_level} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == c_ST_READ) && (w_occ < 3'(c_BUF_ENTRIES));
    assign w_last_pop  = (r_state == c_ST_DRAIN) && w_pop && (r_out_left == c_CNT_W'(1));
    assign done        = !reset && (w_last_pop || r_zero_done);
    assign w_next_addr = c_ADDR_W'(wrap_inc(32'(r_addr), DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_left  <= '0;
            r_inflight  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            r_inflight  <= w_issue;
            if (w_pop && (r_out_left != '0)) begin
                r_out_left <= r_out_left - c_CNT_W'(1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_addr      <= base;
                            r_remaining <= count;
                            r_out_left  <= count;
                            r_state     <= c_ST_READ;
                        end else begin
                            r_zero_done <= 1'b1;
                        end
                    end
                end
                c_ST_READ: begin
                    if (w_issue) begin
                        r_remaining <= r_remaining - c_CNT_W'(1);
                        // The final address stays on the bus rather than running ahead.
                        if (r_remaining == c_CNT_W'(1)) begin
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_addr <= w_next_addr;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk     (clock),
        .rst     (reset),
        .i_valid (r_inflight),
        .i_data  (mem_q),
        .i_ready (out_ready),
        .o_valid (w_buf_valid),
        .o_data  (out_data),
        .o_level (w_level)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// ============================================================================
// tb_mem_stream_reader
// Directed bench for the burst reader against a registered RAM holding RAM[i]=i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stream_reader;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 64;

    typedef struct {
        int base;
        int count;
        int mode;
        int exp_done;
        int dup_at;
    } vec_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic [5:0]        base;
    logic [6:0]        count;
    logic              busy;
    logic              done;
    logic [5:0]        mem_address;
    logic              mem_wr_en;
    logic [c_WIDTH-1:0] mem_q;
    logic [c_WIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic [c_WIDTH-1:0] ram [c_DEPTH];
    int                 n_checks;
    int                 n_errors;
    vec_t               vecs [7];
    logic [3:0]         pat;

    mem_stream_reader #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base        (base),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_wr_en   (mem_wr_en),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= ram[mem_address];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_burst(input int b, input int c, input int mode, input int exp_done, input int dup_at);
        int k;
        int t;
        int done_t;
        logic prev_stall;
        logic [c_WIDTH-1:0] prev_data;
        k = 0;
        done_t = -1;
        prev_stall = 1'b0;
        prev_data = '0;
        for (t = 0; (t < 400) && (done_t < 0); t++) begin
            @(negedge clock);
            start = (t == 0) || (t == dup_at);
            base  = (t == 0) ? 6'(b) : 6'd40;
            count = (t == 0) ? 7'(c) : 7'd3;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[t % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (t == 1) check("addr_first", int'(mem_address), b);
            if (t <= 2) check("valid_early", int'(out_valid), 0);
            if (t == 3) check("valid_t3", int'(out_valid), 1);
            check("busy", int'(busy), (t == 0) ? 0 : 1);
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                check("data", int'(out_data), (b + k) % c_DEPTH);
                k++;
                check("done_on_xfer", int'(done), (k == c) ? 1 : 0);
                if (k == c) done_t = t;
            end else begin
                check("done_quiet", int'(done), 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        start = 1'b0;
        if (done_t < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL burst_timeout: got %0d words expected %0d", k, c);
        end
        check("word_count", k, c);
        if (exp_done >= 0) check("done_cycle", done_t, exp_done);
        @(negedge clock);
        #1;
        check("busy_after", int'(busy), 0);
        check("done_after", int'(done), 0);
        check("valid_after", int'(out_valid), 0);
    endtask

    initial begin
        int k;
        n_checks  = 0;
        n_errors  = 0;
        pat       = 4'b1001;
        reset     = 1'b1;
        start     = 1'b0;
        base      = '0;
        count     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) ram[i] = c_WIDTH'(i);

        vecs[0] = '{5,  4,  0, 6,  -1};
        vecs[1] = '{62, 4,  0, 6,  -1};
        vecs[2] = '{0,  1,  0, 3,  -1};
        vecs[3] = '{10, 16, 1, -1, -1};
        vecs[4] = '{33, 16, 2, -1, -1};
        vecs[5] = '{60, 64, 0, 66, -1};
        vecs[6] = '{8,  6,  0, 8,  2};

        repeat (3) @(negedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_addr", int'(mem_address), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].base, vecs[v].count, vecs[v].mode, vecs[v].exp_done, vecs[v].dup_at);
        end

        // Zero-length request
        @(negedge clock);
        start = 1'b1; base = 6'd7; count = 7'd0; out_ready = 1'b1;
        #1;
        check("zero_done_t0", int'(done), 0);
        @(negedge clock);
        start = 1'b0;
        #1;
        check("zero_done_t1", int'(done), 1);
        check("zero_busy_t1", int'(busy), 0);
        check("zero_valid_t1", int'(out_valid), 0);
        for (int t = 2; t < 6; t++) begin
            @(negedge clock);
            #1;
            check("zero_done_later", int'(done), 0);
            check("zero_busy_later", int'(busy), 0);
            check("zero_valid_later", int'(out_valid), 0);
        end

        // Reset in the middle of a 10-word burst
        @(negedge clock);
        start = 1'b1; base = 6'd20; count = 7'd10; out_ready = 1'b1;
        k = 0;
        for (int t = 1; (t < 40) && (k < 3); t++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (out_valid) begin
                check("abort_data", int'(out_data), 20 + k);
                k++;
            end
        end
        check("abort_pre_words", k, 3);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_rst_done", int'(done), 0);
        check("abort_rst_busy", int'(busy), 0);
        check("abort_rst_valid", int'(out_valid), 0);
        check("abort_rst_addr", int'(mem_address), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_data_zero", int'(out_data), 0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            #1;
            check("abort_no_done", int'(done), 0);
            check("abort_no_valid", int'(out_valid), 0);
        end
        run_burst(30, 5, 0, 7, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
